// File: rtl/button_dir_queue.sv
// Snake-game direction input: synchronise and debounce four buttons, then queue one-hot requests popped on tick.
// Optional REVERSE_LOCK_EN: drop requests opposite the reference direction.
module button_dir_queue #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter logic [3:0]  INIT_DIR        = 4'b0010,
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1),
    localparam int unsigned QW    = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          l,
    input  logic          r,
    input  logic          u,
    input  logic          d,
    input  logic          tick,
    output logic [3:0]    direction,
    output logic [QW-1:0] queue_count,
    output logic          overflow
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [3:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [CNT_W-1:0]       cnt_q  [4];
    logic [3:0]             synced;
    logic [3:0]             stable_q;
    logic [3:0]             stable_prev;
    logic [3:0]             press;

    logic [3:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] last_ptr;
    logic [3:0]    cand;
    logic [3:0]    ref_dir;
    logic          accept;
    logic          do_pop;
    logic          do_push;
    logic          drop_full;

    assign raw = {d, u, r, l};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            stable_q    <= '0;
            stable_prev <= '0;
        end else begin
            stable_prev <= stable_q;
            for (int unsigned i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (synced[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable_q[i] <= ~stable_q[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
        press = stable_q & ~stable_prev;

        // Priority L > R > U > D; lower simultaneous presses are discarded
        cand = '0;
        if (press[0])      cand = 4'b0001;
        else if (press[1]) cand = 4'b0010;
        else if (press[2]) cand = 4'b0100;
        else if (press[3]) cand = 4'b1000;

        last_ptr = (wr_ptr == '0) ? PW'(QUEUE_DEPTH - 1) : wr_ptr - 1'b1;
        ref_dir  = (queue_count != '0) ? mem[last_ptr] : direction;

        accept = (cand != '0) && (cand != ref_dir);
`ifdef REVERSE_LOCK_EN
        if (cand == {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]}) begin
            accept = 1'b0;
        end
`endif
        do_pop    = tick && (queue_count != '0);
        do_push   = accept && ((queue_count != QW'(QUEUE_DEPTH)) || do_pop);
        drop_full = accept && !do_push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
            direction   <= INIT_DIR;
            overflow    <= 1'b0;
        end else begin
            overflow <= drop_full;
            if (do_pop) begin
                direction <= mem[rd_ptr];
                rd_ptr    <= ptr_inc(rd_ptr);
            end
            if (do_push) begin
                mem[wr_ptr] <= cand;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   queue_count <= queue_count + 1'b1;
                2'b01:   queue_count <= queue_count - 1'b1;
                default: queue_count <= queue_count;
            endcase
        end
    end

endmodule

// File: tb/tb_button_dir_queue.sv
// Scoreboard bench for button_dir_queue: directed scenarios then random buttons/ticks/resets vs a queue-based model.
module tb_button_dir_queue;

    localparam int unsigned S     = 2;
    localparam int unsigned DB    = 4;
    localparam int unsigned DEPTH = 2;
    localparam logic [3:0]  INIT  = 4'b0010;
    localparam logic [3:0]  BL = 4'b0001, BR = 4'b0010, BU = 4'b0100, BD = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l = 1'b0, r = 1'b0, u = 1'b0, d = 1'b0, tick = 1'b0;
    logic [3:0] direction;
    logic [1:0] queue_count;
    logic       overflow;

    button_dir_queue #(
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(DB),
        .QUEUE_DEPTH(DEPTH),
        .INIT_DIR(INIT)
    ) dut (
        .clk(clk), .rst(rst), .l(l), .r(r), .u(u), .d(d), .tick(tick),
        .direction(direction), .queue_count(queue_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state (buttons as {d,u,r,l})
    logic [3:0] raw_q[$];
    int         run[4];
    logic [3:0] stab;
    logic [3:0] rise_pend;
    logic [3:0] mdir;
    logic [3:0] mfifo[$];
    int         exp_cnt;
    logic       exp_ovf;
    logic [3:0] sb[$];
    logic [3:0] last_dir;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        for (int i = 0; i < S; i++) raw_q.push_back(4'b0000);
        for (int i = 0; i < 4; i++) run[i] = 0;
        stab = '0;
        rise_pend = '0;
        mdir = INIT;
        mfifo.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic [3:0] b, input logic t);
        logic [3:0] syn, ev, cand, refd;
        logic ok;
        syn = raw_q.pop_front();
        raw_q.push_back(b);
        ev = rise_pend;
        rise_pend = '0;
        // A level is accepted after DB consecutive cycles of disagreement
        for (int i = 0; i < 4; i++) begin
            if (syn[i] != stab[i]) begin
                if (run[i] == DB - 1) begin
                    stab[i] = syn[i];
                    run[i] = 0;
                    if (syn[i]) rise_pend[i] = 1'b1;
                end else begin
                    run[i]++;
                end
            end else begin
                run[i] = 0;
            end
        end
        cand = '0;
        for (int i = 3; i >= 0; i--) if (ev[i]) cand = 4'(1 << i);
        refd = (mfifo.size() > 0) ? mfifo[$] : mdir;
        ok = (cand != 0) && (cand != refd);
`ifdef REVERSE_LOCK_EN
        if (((cand | refd) == 4'b0011) || ((cand | refd) == 4'b1100)) ok = 1'b0;
`endif
        exp_ovf = 1'b0;
        if (t && mfifo.size() > 0) begin
            mdir = mfifo.pop_front();
            sb.push_back(mdir);
        end
        if (ok) begin
            if (mfifo.size() < DEPTH) mfifo.push_back(cand);
            else exp_ovf = 1'b1;
        end
        exp_cnt = mfifo.size();
    endtask

    task automatic cyc(input logic [3:0] b, input logic t);
        @(negedge clk);
        #1;
        {d, u, r, l} = b;
        tick = t;
        @(posedge clk);
        if (!rst) model_step(b, t);
    endtask

    task automatic press(input logic [3:0] b);
        repeat (8) cyc(b, 1'b0);
        repeat (8) cyc(4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_direction", direction, INIT);
        chk("rst_queue_count", queue_count, 0);
        chk("rst_overflow", overflow, 0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        {d, u, r, l} = 4'b0000;
        tick = 1'b0;
    endtask

    // Monitor: per-cycle occupancy/overflow, and every direction change pops the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            last_dir = INIT;
        end else begin
            chk("queue_count", queue_count, exp_cnt);
            chk("overflow", overflow, exp_ovf);
            chk("onehot", $countones(direction), 1);
            if (direction != last_dir) begin
                if (sb.size() == 0) begin
                    chk("dir_unexpected", direction, last_dir);
                end else begin
                    chk("direction", direction, sb.pop_front());
                end
                last_dir = direction;
            end
        end
    end

    initial begin
        model_reset();
        tick = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Bounce shorter than debounce window, then a real press and a tick
        repeat (3) cyc(BU, 1'b0);
        repeat (10) cyc(4'b0000, 1'b0);
        chk("bounce_ignored", queue_count, 0);
        repeat (10) cyc(BU, 1'b0);
        repeat (8) cyc(4'b0000, 1'b0);
        chk("u_queued", queue_count, 1);
        cyc(4'b0000, 1'b1);
        repeat (3) cyc(4'b0000, 1'b0);

        // Reset with one entry queued
        press(BL);
        do_reset();

        // u, l, d without tick: full FIFO, overflow on d, then drain
        press(BU);
        press(BL);
        press(BD);
        chk("full_count", queue_count, 2);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b1);
        repeat (3) cyc(4'b0000, 1'b0);

        // Simultaneous l and u; duplicate r against reference
        do_reset();
        press(BL | BU);
        chk("prio_count", queue_count, 1);
        do_reset();
        press(BR);
        chk("dup_dropped", queue_count, 0);

        // Full FIFO with tick coinciding with a press event
        press(BU);
        press(BL);
        repeat (6) cyc(BD, 1'b0);
        cyc(BD, 1'b1);
        repeat (8) cyc(4'b0000, 1'b0);
        chk("tick_push_count", queue_count, 2);
        repeat (2) cyc(4'b0000, 1'b1);
        repeat (3) cyc(4'b0000, 1'b0);

        // Opposite request (reverse-lock dependent)
        do_reset();
        press(BL);
        cyc(4'b0000, 1'b1);
        repeat (3) cyc(4'b0000, 1'b0);

        // Random phase
        begin
            logic [3:0] btn;
            btn = '0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 7))
                        0: btn = '0;
                        1: btn = 4'($urandom);
                        default: btn = 4'(1 << $urandom_range(0, 3));
                    endcase
                end
                if ($urandom_range(0, 599) == 0) do_reset();
                cyc(btn, ($urandom_range(0, 9) == 0));
            end
        end

        repeat (12) cyc(4'b0000, 1'b0);
        repeat (4) cyc(4'b0000, 1'b1);
        repeat (4) cyc(4'b0000, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
